// File: rtl/factor_pkg.sv
// Shared types and defaults for the trial-division factor sequencer.
// Defaults cover every 8-bit input's primality check.
package factor_pkg;

  localparam int WIDTH_DEF   = 8;
  localparam int MAX_DIV_DEF = 19;
  localparam int FACTORS_W   = MAX_DIV_DEF - 1;
  localparam int DIV_W       = 5;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DIVIDE,
    CHECK,
    DONE
  } state_t;

endpackage

// File: rtl/factor_sequencer_serial_remainder.sv
// Restoring serial remainder unit, one dividend bit per cycle.
// Remainder is valid WIDTH cycles after load and holds until the next load.
module serial_remainder
  import factor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] remainder,
  output logic             valid
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] q;
  logic [CW-1:0]    cnt;
  logic [DIV_W:0]   trial;
  logic [DIV_W:0]   div_ext;

  always_comb begin
    trial   = {remainder, q[WIDTH-1]};
    div_ext = {1'b0, divisor};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remainder <= '0;
      q         <= '0;
      cnt       <= '0;
      valid     <= 1'b0;
    end else if (load) begin
      remainder <= '0;
      q         <= dividend;
      cnt       <= CW'(WIDTH);
      valid     <= 1'b0;
    end else if (cnt != '0) begin
      q     <= q << 1;
      cnt   <= cnt - CW'(1);
      valid <= (cnt == CW'(1));
      if (trial >= div_ext)
        remainder <= DIV_W'(trial - div_ext);
      else
        remainder <= trial[DIV_W-1:0];
    end
  end

endmodule

// File: rtl/factor_sequencer.sv
// Multi-cycle trial-division controller: sweeps divisors 2..MAX_DIVISOR
// through one serial remainder unit and publishes factor bits and a prime flag.
module factor_sequencer
  import factor_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int MAX_DIVISOR = MAX_DIV_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [WIDTH-1:0]       number,
  output logic                   busy,
  output logic                   done,
  output logic [MAX_DIVISOR-2:0] factors,
  output logic                   is_prime
);

  localparam int FW = MAX_DIVISOR - 1;
  localparam int BW = $clog2(WIDTH);
  localparam logic [DIV_W-1:0] D_LAST = DIV_W'(MAX_DIVISOR);

  state_t            state;
  logic [WIDTH-1:0]  n_q;
  logic [DIV_W-1:0]  d;
  logic [BW-1:0]     bit_cnt;
  logic [FW-1:0]     acc;
  logic              composite;

  logic              rem_load;
  logic [DIV_W-1:0]  rem_div;
  logic [DIV_W-1:0]  rem;
  logic              rem_valid;
  logic              hit;
  logic [2*WIDTH-1:0] d_ext;
  logic [2*WIDTH-1:0] d_sq;
  logic [2*WIDTH-1:0] n_ext;
  logic [FW-1:0]     bit_sel;
  logic [FW-1:0]     acc_nxt;
  logic              comp_nxt;
  logic              last_d;
  logic              in_sweep;

  // CHECK reloads the unit with the next divisor in the same cycle.
  always_comb begin
    last_d   = (d == D_LAST);
    in_sweep = (state == LOAD) || (state == DIVIDE)
            || (state == CHECK);
    rem_load = (state == LOAD)
            || ((state == CHECK) && !last_d);
    rem_div  = (state == CHECK) ? d + DIV_W'(1) : d;
    hit      = rem_valid && (rem == '0);
    d_ext    = {{(2*WIDTH-DIV_W){1'b0}}, d};
    d_sq     = d_ext * d_ext;
    n_ext    = {{WIDTH{1'b0}}, n_q};
    bit_sel  = FW'(1) << (d - DIV_W'(2));
    acc_nxt  = acc;
    comp_nxt = composite;
    if (hit && (n_q != '0))
      acc_nxt = acc | bit_sel;
    if (hit && (d_sq <= n_ext))
      comp_nxt = 1'b1;
  end

  serial_remainder #(
    .WIDTH(WIDTH)
  ) u_rem (
    .clk      (clk),
    .reset    (reset),
    .load     (rem_load),
    .dividend (n_q),
    .divisor  (rem_div),
    .remainder(rem),
    .valid    (rem_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      n_q       <= '0;
      d         <= DIV_W'(2);
      bit_cnt   <= '0;
      acc       <= '0;
      composite <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      factors   <= '0;
      is_prime  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && in_sweep) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && !abort) begin
              n_q       <= number;
              d         <= DIV_W'(2);
              acc       <= '0;
              composite <= 1'b0;
              busy      <= 1'b1;
              state     <= LOAD;
            end
          end
          LOAD: begin
            bit_cnt <= '0;
            state   <= DIVIDE;
          end
          DIVIDE: begin
            if (bit_cnt == BW'(WIDTH - 1))
              state <= CHECK;
            else
              bit_cnt <= bit_cnt + BW'(1);
          end
          CHECK: begin
            acc       <= acc_nxt;
            composite <= comp_nxt;
            if (last_d) begin
              factors  <= acc_nxt;
              is_prime <= (n_q >= WIDTH'(2)) && !comp_nxt;
              done     <= 1'b1;
              state    <= DONE;
            end else begin
              d       <= d + DIV_W'(1);
              bit_cnt <= '0;
              state   <= DIVIDE;
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_factor_sequencer.sv
// Directed scoreboard bench for factor_sequencer.
// Expected results come from a behavioural trial-division model.
module tb_factor_sequencer;

  localparam int W   = 8;
  localparam int MD  = 19;
  localparam int FW  = MD - 1;
  localparam int LAT = 2 + (MD - 1) * (W + 1);

  typedef struct packed {
    logic [FW-1:0] f;
    logic          p;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [W-1:0]  number;
  logic          busy;
  logic          done;
  logic [FW-1:0] factors;
  logic          is_prime;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  factor_sequencer #(
    .WIDTH(W),
    .MAX_DIVISOR(MD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .number  (number),
    .busy    (busy),
    .done    (done),
    .factors (factors),
    .is_prime(is_prime)
  );

  function automatic exp_t model(input int n);
    exp_t e;
    bit   comp;
    e.f  = '0;
    comp = 1'b0;
    for (int dv = 2; dv <= MD; dv++) begin
      if ((n % dv) == 0) begin
        if (n != 0) e.f[dv-2] = 1'b1;
        if (dv * dv <= n) comp = 1'b1;
      end
    end
    e.p = (n >= 2) && !comp;
    return e;
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the IDLE cycle after DONE.
  task automatic run(input int n, input bit poke);
    int   k;
    int   extra;
    bit   seen;
    exp_t e;
    exp_q.push_back(model(n));
    number = W'(n);
    start  = 1'b1;
    k      = 0;
    seen   = 1'b0;
    while (!seen && k < 400) begin
      @(negedge clk);
      k++;
      start = 1'b0;
      if (k == 1) check("busy_after_accept", 32'(busy), 1);
      if (k == 2) number = ~W'(n);
      if (poke && k == 30) begin
        start  = 1'b1;
        number = 8'd7;
      end
      seen = done;
    end
    check("done_seen", 32'(seen), 1);
    check("latency", k, LAT);
    e = exp_q.pop_front();
    check("factors", 32'(factors), 32'(e.f));
    check("is_prime", 32'(is_prime), 32'(e.p));
    check("busy_in_done", 32'(busy), 1);
    if (poke) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_single", 32'(done), 0);
    check("busy_idle", 32'(busy), 0);
    if (poke) begin
      extra = 0;
      for (int i = 0; i < LAT + 10; i++) begin
        @(negedge clk);
        if (done || busy) extra++;
      end
      check("ignored_starts", extra, 0);
    end
  endtask

  initial begin
    int k;
    int cnt;
    reset  = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    number = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy || done || factors != '0 || is_prime) cnt++;
    end
    check("reset_quiet", cnt, 0);
    check("reset_factors", 32'(factors), 0);

    run(12, 1'b0);
    run(17, 1'b1);
    run(251, 1'b0);
    run(255, 1'b0);
    run(0, 1'b0);
    run(1, 1'b0);
    run(12, 1'b0);
    check("f12", 32'(factors), 32'h417);

    number = 8'd255;
    start  = 1'b1;
    for (k = 1; k <= 50; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 0);
    cnt = 0;
    for (int i = 0; i < LAT + 10; i++) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    check("abort_no_done", cnt, 0);
    check("abort_factors", 32'(factors), 32'h417);
    check("abort_prime", 32'(is_prime), 0);

    number = 8'd17;
    start  = 1'b1;
    abort  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy || done) cnt++;
      @(negedge clk);
    end
    check("start_abort_idle", cnt, 0);
    check("sa_factors", 32'(factors), 32'h417);

    number = 8'd12;
    start  = 1'b1;
    for (k = 1; k <= 80; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    #1;
    check("rst_factors", 32'(factors), 0);
    check("rst_prime", 32'(is_prime), 0);
    check("rst_busy", 32'(busy), 0);
    @(negedge clk);
    reset = 1'b0;
    run(17, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/factor_sequencer.md
# factor_sequencer

Multi-cycle trial-division controller that replaces the combinational factor datapath behind the switch inputs. On a `start` pulse it captures an 8-bit number and sweeps divisors 2..MAX_DIVISOR through one shared serial remainder unit. It then publishes the same factor-bit vector and prime flag that the display and GPIO logic already consume. The top level drives `start` when the switch value changes and `abort` when it changes again mid-sweep.

## Interface
- `WIDTH`, 8: width of the number under test.
- `MAX_DIVISOR`, 19: largest trial divisor; factor vector width is MAX_DIVISOR-1.
- `clk`  in  1  system clock (10 MHz on the board).
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a new factorization; sampled only in IDLE.
- `abort`  in  1  cancel the sweep in progress.
- `number`  in  WIDTH  value to factor; sampled on the accepting `start` edge.
- `busy`  out  1  high from the cycle after accept until DONE is left.
- `done`  out  1  single-cycle pulse when new results are valid.
- `factors`  out  MAX_DIVISOR-1  bit i set iff (i+2) divides the number.
- `is_prime`  out  1  number ≥ 2 and no divisor d with d·d ≤ number.

## Operation
- States: IDLE → LOAD → DIVIDE ↔ CHECK → DONE → IDLE.
- IDLE:
  - `start`=1 with `abort`=0: latch `number` into n_q, set d=2, clear the accumulators, go to LOAD.
  - `abort` has priority over `start` in the same cycle.
- LOAD (1 cycle): pulse start to the remainder unit with dividend n_q and divisor d.
- DIVIDE (WIDTH cycles): the remainder unit performs restoring division, one dividend bit per cycle.
- CHECK (1 cycle):
  - If remainder==0 and n_q≠0: set acc[d-2].
  - If remainder==0 and d·d ≤ n_q: set composite flag.
  - If d==MAX_DIVISOR: go to DONE. Otherwise d←d+1 and return to DIVIDE, restarting the unit in the same cycle.
- DONE (1 cycle):
  - `factors`←acc.
  - `is_prime`←(n_q≥2) & !composite.
  - `done`=1, `busy`=1. Then go to IDLE.
- `abort` in LOAD/DIVIDE/CHECK: go to IDLE on the next edge. No `done`; `factors` and `is_prime` are unchanged.
- `abort` in DONE is ignored; the results still publish.
- `start` outside IDLE is ignored, with no queuing. `number` changes after accept are ignored.
- Special values:
  - n=0: factors=0, is_prime=0.
  - n=1: factors=0, is_prime=0.
  - Full sweep latency applies regardless of value.
- d·d uses a 2·WIDTH-bit product; no truncation.
- With defaults, MAX_DIVISOR ≥ √255 covers the primality check for every 8-bit input.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `factors`=0, `is_prime`=0, all accumulators 0.
- Accept edge = E0. LOAD occupies cycle E0+1.
- `done` is high in exactly one cycle, 2+(MAX_DIVISOR-1)·(WIDTH+1) cycles after E0. That is 164 cycles with defaults.
- `factors`/`is_prime` change only on the edge that enters DONE. They are valid from the `done` cycle and hold until the next DONE or reset.
- Back-to-back: earliest next accept is the IDLE cycle after DONE. Start-to-start is 165 cycles.
- `abort` sampled at edge Ek: `busy`=0 from Ek+1.
- Reset asserted mid-sweep clears everything asynchronously. Sampling resumes from IDLE on the first edge after deassertion.

## Structure
- Package `factor_pkg`: WIDTH and MAX_DIVISOR defaults, state encoding constants (IDLE, LOAD, DIVIDE, CHECK, DONE), derived FACTORS_W = MAX_DIVISOR-1.
- Sub-module `serial_remainder`:
  - Inputs: `clk`, `reset`, `load`, `dividend`[WIDTH], `divisor`[5].
  - Outputs: `remainder`[5], `valid`.
  - Restoring algorithm, WIDTH cycles after `load`.
- The sequencer owns only the FSM, divisor counter, bit-cycle counter and accumulators.

## Test plan
- Reset held, then released with `start` low → all outputs 0, `busy` 0 for 20 cycles.
- `number`=12, `start` 1 cycle → `done` exactly 164 cycles later; `factors`=0x00417, `is_prime`=0.
- `number`=17 → `factors`=0x08000, `is_prime`=1. `number`=251 → `factors`=0x00000, `is_prime`=1.
- `number`=255 → `factors`=0x0A00A, `is_prime`=0. Then `number`=0 and `number`=1 → `factors`=0, `is_prime`=0.
- After a 12 result, start with 255 and assert `abort` at cycle 50 → `busy`=0 next cycle, no `done`, outputs still 0x00417/0. Simultaneous `start`+`abort` in IDLE → no accept.
- `start` pulses while `busy` and during DONE → ignored, with a single `done` per accept. Reset at cycle 80 of a sweep → outputs 0 immediately; a fresh `start` completes in 164 cycles.
